// File: rtl/bar_sram_server.sv
// rtl/bar_sram_server.sv - eight-bar 64-bit note store on an async 16-bit SRAM, two-cycle word access.
// Optional power-up zero fill of all 32 words when BAR_SRAM_CLEAR_EN is defined.
module bar_sram_server #(
    parameter logic [17:0] BASE_ADDR = 18'h00000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        i_rd_req,
    input  logic [3:0]  i_bar,
    output logic        o_read_n,
    output logic [63:0] o_note,
    input  logic        i_wr_req,
    input  logic [3:0]  i_wr_bar,
    input  logic [63:0] i_wr_note,
    output logic        o_wr_done,
    output logic [7:0]  o_bar_map,
    output logic        o_busy,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

`ifdef BAR_SRAM_CLEAR_EN
    localparam logic CLEAR_EN = 1'b1;
`else
    localparam logic CLEAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, INIT, RD_ADDR, RD_SAMPLE, RD_DONE, WR_ADDR, WR_PULSE, WR_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        rd_req_q, rd_req_d;
    logic        rd_pend_q, rd_pend_d;
    logic [3:0]  rd_bar_q, rd_bar_d;
    logic        wr_pend_q, wr_pend_d;
    logic [3:0]  wr_bar_q, wr_bar_d;
    logic [63:0] wr_note_q, wr_note_d;
    logic [63:0] act_note_q, act_note_d;
    logic [4:0]  idx_q, idx_d;
    logic        clr_act_q, clr_act_d;
    logic        clr_pend_q, clr_pend_d;
    logic [47:0] rbuf_q, rbuf_d;
    logic [63:0] note_q, note_d;
    logic [7:0]  map_q, map_d;
    logic [17:0] addr_q, addr_d;

    logic        wr_taken;
    logic [3:0]  wb;
    logic [63:0] wn;
    logic        access, drive;
    logic [15:0] wdata;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q    <= IDLE;
            rd_req_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_bar_q   <= 4'd0;
            wr_pend_q  <= 1'b0;
            wr_bar_q   <= 4'd0;
            wr_note_q  <= 64'd0;
            act_note_q <= 64'd0;
            idx_q      <= 5'd0;
            clr_act_q  <= 1'b0;
            clr_pend_q <= CLEAR_EN;
            rbuf_q     <= 48'd0;
            note_q     <= 64'd0;
            map_q      <= 8'd0;
            addr_q     <= BASE_ADDR;
        end else begin
            state_q    <= state_d;
            rd_req_q   <= rd_req_d;
            rd_pend_q  <= rd_pend_d;
            rd_bar_q   <= rd_bar_d;
            wr_pend_q  <= wr_pend_d;
            wr_bar_q   <= wr_bar_d;
            wr_note_q  <= wr_note_d;
            act_note_q <= act_note_d;
            idx_q      <= idx_d;
            clr_act_q  <= clr_act_d;
            clr_pend_q <= clr_pend_d;
            rbuf_q     <= rbuf_d;
            note_q     <= note_d;
            map_q      <= map_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_req_d   = i_rd_req;
        rd_pend_d  = rd_pend_q;
        rd_bar_d   = rd_bar_q;
        wr_pend_d  = wr_pend_q;
        wr_bar_d   = wr_bar_q;
        wr_note_d  = wr_note_q;
        act_note_d = act_note_q;
        idx_d      = idx_q;
        clr_act_d  = clr_act_q;
        clr_pend_d = clr_pend_q;
        rbuf_d     = rbuf_q;
        note_d     = note_q;
        map_d      = map_q;
        addr_d     = addr_q;
        wr_taken   = 1'b0;
        wb         = i_wr_req ? i_wr_bar : wr_bar_q;
        wn         = i_wr_req ? i_wr_note : wr_note_q;

        case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    state_d    = INIT;
                    clr_pend_d = 1'b0;
                    clr_act_d  = 1'b1;
                    idx_d      = 5'd0;
                    act_note_d = 64'd0;
                end else if (i_wr_req || wr_pend_q) begin
                    // A strobe arriving in IDLE is served this cycle, so it never lands in the pending slot.
                    wr_taken  = 1'b1;
                    wr_pend_d = 1'b0;
                    if (!wb[3]) begin
                        state_d    = WR_ADDR;
                        idx_d      = {wb[2:0], 2'b00};
                        act_note_d = wn;
                    end
                end else if (rd_pend_q) begin
                    rd_pend_d = 1'b0;
                    idx_d     = {rd_bar_q[2:0], 2'b00};
                    if (!rd_bar_q[3] && map_q[rd_bar_q[2:0]]) begin
                        state_d = RD_ADDR;
                    end else begin
                        state_d = RD_DONE;
                        note_d  = 64'd0;
                    end
                end
            end
            INIT:    state_d = WR_PULSE;
            WR_ADDR: state_d = WR_PULSE;
            WR_PULSE: begin
                if (clr_act_q) begin
                    if (idx_q == 5'd31) begin
                        state_d   = IDLE;
                        clr_act_d = 1'b0;
                    end else begin
                        state_d = INIT;
                        idx_d   = idx_q + 5'd1;
                    end
                end else if (idx_q[1:0] == 2'd3) begin
                    state_d               = WR_DONE;
                    map_d[idx_q[4:2]]     = 1'b1;
                end else begin
                    state_d = WR_ADDR;
                    idx_d   = idx_q + 5'd1;
                end
            end
            RD_ADDR: state_d = RD_SAMPLE;
            RD_SAMPLE: begin
                case (idx_q[1:0])
                    2'd0: rbuf_d[15:0]  = SRAM_DQ;
                    2'd1: rbuf_d[31:16] = SRAM_DQ;
                    2'd2: rbuf_d[47:32] = SRAM_DQ;
                    default: ;
                endcase
                if (idx_q[1:0] == 2'd3) begin
                    state_d = RD_DONE;
                    note_d  = {SRAM_DQ, rbuf_q};
                end else begin
                    state_d = RD_ADDR;
                    idx_d   = idx_q + 5'd1;
                end
            end
            RD_DONE: state_d = IDLE;
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (i_wr_req && !wr_taken) begin
            wr_pend_d = 1'b1;
            wr_bar_d  = i_wr_bar;
            wr_note_d = i_wr_note;
        end
        if (i_rd_req && !rd_req_q) begin
            rd_pend_d = 1'b1;
            rd_bar_d  = i_bar;
        end
        // Address is registered one cycle ahead so it is stable for the whole access.
        if (state_d inside {INIT, RD_ADDR, RD_SAMPLE, WR_ADDR, WR_PULSE}) begin
            addr_d = BASE_ADDR + {13'd0, idx_d};
        end
    end

    always_comb begin
        case (idx_q[1:0])
            2'd0:    wdata = act_note_q[15:0];
            2'd1:    wdata = act_note_q[31:16];
            2'd2:    wdata = act_note_q[47:32];
            default: wdata = act_note_q[63:48];
        endcase
    end

    assign access    = state_q inside {INIT, RD_ADDR, RD_SAMPLE, WR_ADDR, WR_PULSE};
    assign drive     = state_q inside {INIT, WR_ADDR, WR_PULSE};
    assign SRAM_DQ   = drive ? wdata : 16'hzzzz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = ~access;
    assign SRAM_UB_N = ~access;
    assign SRAM_LB_N = ~access;
    assign SRAM_OE_N = ~(state_q == RD_ADDR || state_q == RD_SAMPLE);
    assign SRAM_WE_N = ~(state_q == WR_PULSE);

    assign o_read_n  = (state_q == RD_DONE);
    assign o_wr_done = (state_q == WR_DONE);
    assign o_busy    = (state_q != IDLE);
    assign o_note    = note_q;
    assign o_bar_map = map_q;

endmodule

// File: tb/tb_bar_sram_server.sv
// tb/tb_bar_sram_server.sv - directed self-checking bench for bar_sram_server with a behavioural SRAM.
module tb_bar_sram_server;
    logic        iCLK = 1'b0;
    logic        iRST;
    logic        i_rd_req, i_wr_req;
    logic [3:0]  i_bar, i_wr_bar;
    logic [63:0] i_wr_note;
    logic        o_read_n, o_wr_done, o_busy;
    logic [63:0] o_note;
    logic [7:0]  o_bar_map;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] sram_dq;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
    wire  [4:0]  strb = {SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N};

    localparam logic [63:0] N1 = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [63:0] N2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] N3 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] NA = 64'h1111_2222_3333_4444;
    localparam logic [63:0] NB = 64'hA5A5_5A5A_C3C3_3C3C;

    int n_tests = 0;
    int n_fail  = 0;
    int ce_low_cnt = 0, wr_done_cnt = 0, rd_cnt = 0, overlap_cnt = 0;
    logic        fill_ff = 1'b1;
    logic [15:0] mem [0:255];

    bar_sram_server dut (
        .iCLK(iCLK), .iRST(iRST), .i_rd_req(i_rd_req), .i_bar(i_bar),
        .o_read_n(o_read_n), .o_note(o_note), .i_wr_req(i_wr_req),
        .i_wr_bar(i_wr_bar), .i_wr_note(i_wr_note), .o_wr_done(o_wr_done),
        .o_bar_map(o_bar_map), .o_busy(o_busy), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ(sram_dq), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 iCLK = ~iCLK;

    assign sram_dq = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;

    always @(posedge iCLK) begin
        if (fill_ff) begin
            for (int k = 0; k < 256; k++) mem[k] <= 16'hFFFF;
        end else if (!SRAM_CE_N && !SRAM_WE_N) begin
            mem[SRAM_ADDR[7:0]] <= sram_dq;
        end
    end

    always @(negedge iCLK) begin
        if (!SRAM_CE_N) ce_low_cnt++;
        if (o_wr_done) wr_done_cnt++;
        if (o_read_n) rd_cnt++;
        if (!SRAM_WE_N && !SRAM_OE_N) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr_strobe(input logic [3:0] b, input logic [63:0] n);
        @(negedge iCLK);
        i_wr_req = 1'b1; i_wr_bar = b; i_wr_note = n;
        @(negedge iCLK);
        i_wr_req = 1'b0;
    endtask

    task automatic rd_edge(input logic [3:0] b);
        @(negedge iCLK);
        i_rd_req = 1'b1; i_bar = b;
        @(negedge iCLK);
    endtask

    task automatic wait_pulse(input logic sel_rd, input int limit, output int lat);
        int i;
        lat = 0;
        i = 0;
        while (lat == 0 && i < limit) begin
            @(negedge iCLK);
            i++;
            if (sel_rd ? o_read_n : o_wr_done) lat = i;
        end
    endtask

    task automatic count_busy(output int busy_n);
        int i;
        busy_n = 0;
        i = 0;
        while (i < 200 && !(busy_n > 0 && !o_busy)) begin
            @(negedge iCLK);
            i++;
            if (o_busy) busy_n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, wl, rl, snap_wr, snap_rd, snap_ce, busy_n;
        logic found;
        logic [15:0] acc;
        iRST = 1'b0; i_rd_req = 1'b0; i_bar = 4'd0;
        i_wr_req = 1'b0; i_wr_bar = 4'd0; i_wr_note = 64'd0;
        repeat (3) @(negedge iCLK);
        fill_ff = 1'b0;
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        check("rst_read_n", {63'd0, o_read_n}, 64'd0);
        check("rst_wr_done", {63'd0, o_wr_done}, 64'd0);
        check("rst_map", {56'd0, o_bar_map}, 64'd0);
        check("rst_note", o_note, 64'd0);
        check("rst_addr", {46'd0, SRAM_ADDR}, 64'd0);
        check("rst_strobes", {59'd0, strb}, 64'h1F);
        iRST = 1'b1;
`ifdef BAR_SRAM_CLEAR_EN
        count_busy(busy_n);
        check("init_busy_cycles", busy_n, 64);
`else
        @(negedge iCLK);
        check("idle_after_release", {63'd0, o_busy}, 64'd0);
`endif

        wr_strobe(4'd2, N2);
        wait_pulse(1'b0, 20, lat);
        check("wr_latency", lat, 8);
        @(negedge iCLK);
        check("wr_pulse_width", {63'd0, o_wr_done}, 64'd0);
        check("mem_w0", {48'd0, mem[8]}, 64'hCDEF);
        check("mem_w1", {48'd0, mem[9]}, 64'h89AB);
        check("mem_w2", {48'd0, mem[10]}, 64'h4567);
        check("mem_w3", {48'd0, mem[11]}, 64'h0123);
        check("map_bar2", {56'd0, o_bar_map}, 64'h04);

        snap_rd = rd_cnt;
        rd_edge(4'd2);
        wait_pulse(1'b1, 20, lat);
        check("rd_latency", lat, 9);
        check("rd_note", o_note, N2);
        repeat (12) @(negedge iCLK);
        i_rd_req = 1'b0;
        repeat (3) @(negedge iCLK);
        check("rd_single_pulse", rd_cnt - snap_rd, 1);

        snap_ce = ce_low_cnt;
        rd_edge(4'd5);
        wait_pulse(1'b1, 20, lat);
        check("skip5_latency", lat, 1);
        check("skip5_note", o_note, 64'd0);
        i_rd_req = 1'b0;
        rd_edge(4'd8);
        wait_pulse(1'b1, 20, lat);
        check("skip8_latency", lat, 1);
        check("skip8_note", o_note, 64'd0);
        i_rd_req = 1'b0;
        rd_edge(4'd10);
        wait_pulse(1'b1, 20, lat);
        check("skip10_latency", lat, 1);
        i_rd_req = 1'b0;
        @(negedge iCLK);
        check("skip_no_sram", ce_low_cnt - snap_ce, 0);

        snap_wr = wr_done_cnt;
        snap_ce = ce_low_cnt;
        wr_strobe(4'd12, N1);
        repeat (12) @(negedge iCLK);
        check("drop_no_done", wr_done_cnt - snap_wr, 0);
        check("drop_no_sram", ce_low_cnt - snap_ce, 0);
        check("drop_map", {56'd0, o_bar_map}, 64'h04);

        @(negedge iCLK);
        i_wr_req = 1'b1; i_wr_bar = 4'd3; i_wr_note = N3;
        i_rd_req = 1'b1; i_bar = 4'd3;
        @(negedge iCLK);
        i_wr_req = 1'b0;
        wl = 0; rl = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge iCLK);
            if (o_wr_done && wl == 0) wl = i;
            if (o_read_n && rl == 0) rl = i;
        end
        i_rd_req = 1'b0;
        check("same_cycle_wr_lat", wl, 8);
        check("same_cycle_rd_lat", rl, 18);
        check("same_cycle_note", o_note, N3);
        check("same_cycle_map", {56'd0, o_bar_map}, 64'h0C);

        snap_wr = wr_done_cnt;
        rd_edge(4'd2);
        wr_strobe(4'd4, NA);
        wr_strobe(4'd6, NB);
        i_rd_req = 1'b0;
        repeat (30) @(negedge iCLK);
        check("last_wins_one_done", wr_done_cnt - snap_wr, 1);
        check("last_wins_map", {56'd0, o_bar_map}, 64'h4C);
        check("read_before_writes", o_note, N2);
        rd_edge(4'd6);
        wait_pulse(1'b1, 20, lat);
        i_rd_req = 1'b0;
        check("last_wins_note", o_note, NB);

        snap_wr = wr_done_cnt;
        wr_strobe(4'd1, N1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge iCLK);
            if (!SRAM_WE_N) found = 1'b1;
        end
        check("we_pulse_seen", {63'd0, found}, 64'd1);
        iRST = 1'b0;
        #1;
        check("abort_strobes", {59'd0, strb}, 64'h1F);
        check("abort_map", {56'd0, o_bar_map}, 64'd0);
        check("abort_busy", {63'd0, o_busy}, 64'd0);
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
`ifdef BAR_SRAM_CLEAR_EN
        count_busy(busy_n);
`else
        @(negedge iCLK);
        check("idle_after_abort", {63'd0, o_busy}, 64'd0);
`endif
        repeat (15) @(negedge iCLK);
        check("abort_no_done", wr_done_cnt - snap_wr, 0);
        check("abort_map_after", {56'd0, o_bar_map}, 64'd0);
        check("abort_note", o_note, 64'd0);

`ifdef BAR_SRAM_CLEAR_EN
        @(negedge iCLK);
        fill_ff = 1'b1;
        @(negedge iCLK);
        fill_ff = 1'b0;
        iRST = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
        count_busy(busy_n);
        check("clear_busy_cycles", busy_n, 64);
        acc = 16'd0;
        for (int k = 0; k < 32; k++) acc = acc | mem[k];
        check("clear_all_zero", {48'd0, acc}, 64'd0);
        check("clear_no_done", wr_done_cnt - snap_wr, 0);
`endif

        check("we_oe_never_both_low", overlap_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bar_sram_server.md
BAR_SRAM_SERVER -- requirements
Module: bar_sram_server

Interface
REQ-001 Parameter: BASE_ADDR, default 18'h00000, word address of bar 0 word 0 in SRAM.
REQ-002 iCLK  input  1  system clock; all state updates on rising edge.
REQ-003 iRST  input  1  asynchronous, active-low reset.
REQ-004 i_rd_req  input  1  bar read request level; acted on at rising edge only.
REQ-005 i_bar  input  4  bar index to read, sampled with the i_rd_req rising edge.
REQ-006 o_read_n  output  1  read-complete pulse, one cycle, active high.
REQ-007 o_note  output  64  note word returned by the last read; held until the next completion.
REQ-008 i_wr_req  input  1  one-cycle save strobe.
REQ-009 i_wr_bar  input  4  bar index to write, sampled with i_wr_req.
REQ-010 i_wr_note  input  64  note word to store, sampled with i_wr_req.
REQ-011 o_wr_done  output  1  write-complete pulse, one cycle.
REQ-012 o_bar_map  output  8  bit n high means bar n holds a stored note word.
REQ-013 o_busy  output  1  high whenever the state is not IDLE.
REQ-014 SRAM_ADDR  output  18  SRAM word address.
REQ-015 SRAM_DQ  inout  16  SRAM data; driven only in write states, else high-Z.
REQ-016 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  SRAM strobes, active low.

Function
REQ-017 The SRAM address shall be BASE_ADDR + {bar[2:0], word[1:0]}; word k shall hold note[16k+15:16k].
REQ-018 The states shall be IDLE, INIT, RD_ADDR, RD_SAMPLE, RD_DONE, WR_ADDR, WR_PULSE and WR_DONE.
REQ-019 A registered edge detector on i_rd_req shall latch a read pending flag and i_bar; a level held high shall never start a second read.
REQ-020 i_wr_req shall latch a write pending flag plus i_wr_bar and i_wr_note; a new strobe while a write is pending shall overwrite it (last wins).
REQ-021 In IDLE, a pending write shall be served before a pending read, including when both arrive in the same cycle.
REQ-022 Read per word: RD_ADDR drives the address with OE_N=0; RD_SAMPLE captures SRAM_DQ. Four words, then RD_DONE.
REQ-023 In RD_DONE, o_note shall update and o_read_n shall pulse; with the block idle, this is exactly 9 cycles after the cycle that samples the edge.
REQ-024 Write per word: WR_ADDR drives address and data with WE_N=1; WR_PULSE holds both with WE_N=0. Four words, then WR_DONE.
REQ-025 WR_DONE shall pulse o_wr_done and set o_bar_map[i_wr_bar]; the write completes 8 cycles after the strobe when idle.
REQ-026 A read of a bar index of 8 or more, or of a bar whose map bit is 0, shall skip SRAM, load o_note=0 and pulse o_read_n one cycle after being taken from IDLE.
REQ-027 A write to a bar index of 8 or more shall be dropped with no SRAM access, no map change and no o_wr_done.
REQ-028 CE_N, UB_N and LB_N shall be 0 in all SRAM access states and 1 otherwise; WE_N and OE_N shall never both be 0.
REQ-029 Outside access states, SRAM_ADDR shall hold its last value and SRAM_DQ shall be high-Z.

Reset
REQ-030 While iRST=0: state=IDLE, all pending flags cleared, o_note=0, o_read_n=0, o_wr_done=0, o_bar_map=0, o_busy=0, all SRAM strobes=1, SRAM_DQ high-Z, SRAM_ADDR=BASE_ADDR.
REQ-031 A reset asserted mid-access shall abort the access immediately, with no completion pulse and no map update.

Configuration
REQ-032 Macro BAR_SRAM_CLEAR_EN defined: after reset release, INIT shall write zero to all 32 words using WR_ADDR/WR_PULSE timing; o_busy=1 for 64 cycles; requests arriving meanwhile shall stay pending; no o_wr_done and no map change.
REQ-033 Macro BAR_SRAM_CLEAR_EN undefined: INIT shall be unreachable, and the block is IDLE on the first cycle after reset release.

Verification
REQ-034 Write bar 2 = 64'h0123_4567_89AB_CDEF -> SRAM words 0x08..0x0B = CDEF, 89AB, 4567, 0123; o_wr_done 8 cycles later; o_bar_map = 8'h04.
REQ-035 Read bar 2, i_rd_req held high 20 cycles -> exactly one o_read_n pulse, 9 cycles after the edge, o_note = 64'h0123_4567_89AB_CDEF.
REQ-036 Read bar 5 (unwritten) and read bar 8 -> o_read_n one cycle after each is taken, o_note = 0, SRAM strobes stay high.
REQ-037 Write strobe and read edge in the same cycle, both on bar 3 -> write completes first, then the read returns the new data.
REQ-038 iRST pulsed low during a WR_PULSE -> strobes go to 1 asynchronously, o_bar_map = 0, no o_wr_done.
REQ-039 With BAR_SRAM_CLEAR_EN defined, prefill SRAM with 16'hFFFF and reset -> o_busy high 64 cycles, all 32 words read back 0.
